// File: rtl/mul_bist_ctrl.sv
// BIST controller: loads operand LFSRs, streams num_vec vectors through the multiplier and folds products into a rotate-XOR signature.
// Start-to-done is num_vec+LAT+3 cycles; there is no backpressure, start is ignored while busy and abort overrides every transition.
module mul_bist_ctrl #(
    parameter int N     = 32,
    parameter int CNT_W = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [N-1:0]     seed_a,
    input  logic [N-1:0]     seed_b,
    input  logic [N-1:0]     mask,
    input  logic [2*N-1:0]   golden,
    input  logic [2*N-1:0]   prod,
    output logic             lfsr_rst,
    output logic [N-1:0]     lfsr_seed_a,
    output logic [N-1:0]     lfsr_seed_b,
    output logic [N-1:0]     lfsr_mask,
    output logic             vec_valid,
    output logic [2*N-1:0]   sig,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, CHECK} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [2:0]       DRAIN_LAST = 3'((LAT > 0) ? LAT - 1 : 0);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   num_vec_q;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         dcnt;
    logic [2*N-1:0]     golden_q;
    logic               vld_d;
    logic               abort_hit;

    assign abort_hit = abort && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD: begin
                if (num_vec_q != '0)   state_nxt = RUN;
                else                   state_nxt = (LAT == 0) ? CHECK : DRAIN;
            end
            RUN:     if (cnt == num_vec_q - CNT_ONE) state_nxt = (LAT == 0) ? CHECK : DRAIN;
            DRAIN:   if (dcnt == DRAIN_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    // LFSRs only step in RUN; every other state holds them in load.
    always_comb begin
        lfsr_rst  = (state != RUN);
        vec_valid = (state == RUN);
        busy      = (state != IDLE);
    end

    generate
        if (LAT == 0) begin : g_no_dly
            assign vld_d = vec_valid;
        end else begin : g_dly
            logic [LAT-1:0] dly;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly <= '0;
                end else if (state == LOAD) begin
                    dly <= '0;
                end else begin
                    dly <= LAT'({dly, vec_valid});
                end
            end
            assign vld_d = dly[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_vec_q   <= '0;
            golden_q    <= '0;
            lfsr_seed_a <= '0;
            lfsr_seed_b <= '0;
            lfsr_mask   <= '0;
            cnt         <= '0;
            dcnt        <= '0;
            sig         <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        num_vec_q   <= num_vec;
                        golden_q    <= golden;
                        lfsr_seed_a <= seed_a;
                        lfsr_seed_b <= seed_b;
                        lfsr_mask   <= mask;
                        pass        <= 1'b0;
                    end
                end
                LOAD: begin
                    cnt  <= '0;
                    dcnt <= '0;
                end
                RUN:   cnt  <= cnt + CNT_ONE;
                DRAIN: dcnt <= dcnt + 3'd1;
                CHECK: begin
                    pass <= (sig == golden_q);
                    done <= 1'b1;
                end
                default: ;
            endcase
            if (abort_hit) begin
                done <= 1'b1;
                pass <= 1'b0;
            end
            // Signature is frozen in IDLE so an aborted run cannot keep folding late products.
            if (state == LOAD) begin
                sig <= '0;
            end else if (vld_d && (state != IDLE)) begin
                sig <= {sig[2*N-2:0], sig[2*N-1]} ^ prod;
            end
        end
    end

endmodule

// File: tb/tb_mul_bist_ctrl.sv
// Bench for mul_bist_ctrl: behavioural LFSRs and a 2-stage ideal multiplier feed the LAT=2 instance,
// a LAT=0 instance covers the null run; results are scoreboarded against a reference signature model.
module tb_mul_bist_ctrl;

    localparam int N  = 8;
    localparam int CW = 16;
    localparam int L  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [CW-1:0]   num_vec = '0;
    logic [N-1:0]    seed_a = '0, seed_b = '0, mask = '0;
    logic [2*N-1:0]  golden = '0;
    logic [2*N-1:0]  prod;
    logic [2*N-1:0]  prod0;
    bit              zero_prod = 1'b0;

    logic            lfsr_rst, vec_valid, busy, done, pass;
    logic [N-1:0]    lsa, lsb, lm;
    logic [2*N-1:0]  sig;
    logic            lfsr_rst0, vec_valid0, busy0, done0, pass0;
    logic [N-1:0]    lsa0, lsb0, lm0;
    logic [2*N-1:0]  sig0;

    mul_bist_ctrl #(.N(N), .CNT_W(CW), .LAT(L)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
        .seed_a(seed_a), .seed_b(seed_b), .mask(mask), .golden(golden), .prod(prod),
        .lfsr_rst(lfsr_rst), .lfsr_seed_a(lsa), .lfsr_seed_b(lsb), .lfsr_mask(lm),
        .vec_valid(vec_valid), .sig(sig), .busy(busy), .done(done), .pass(pass)
    );

    assign prod0 = '0;
    mul_bist_ctrl #(.N(N), .CNT_W(CW), .LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
        .seed_a(seed_a), .seed_b(seed_b), .mask(mask), .golden(golden), .prod(prod0),
        .lfsr_rst(lfsr_rst0), .lfsr_seed_a(lsa0), .lfsr_seed_b(lsb0), .lfsr_mask(lm0),
        .vec_valid(vec_valid0), .sig(sig0), .busy(busy0), .done(done0), .pass(pass0)
    );

    function automatic logic [N-1:0] lfsr_nx(input logic [N-1:0] q, input logic [N-1:0] m);
        return (q >> 1) ^ (q[0] ? m : '0);
    endfunction

    function automatic logic [2*N-1:0] model(input int nv, input logic [N-1:0] sa, input logic [N-1:0] sb,
                                             input logic [N-1:0] m, input bit zero);
        logic [N-1:0]   a, b;
        logic [2*N-1:0] s, p;
        a = sa; b = sb; s = '0;
        for (int i = 0; i < nv; i++) begin
            p = zero ? '0 : (16'(a) * 16'(b));
            s = {s[2*N-2:0], s[2*N-1]} ^ p;
            a = lfsr_nx(a, m);
            b = lfsr_nx(b, m);
        end
        return s;
    endfunction

    // Operand LFSRs and ideal 2-stage multiplier around the LAT=2 instance.
    logic [N-1:0]   la = '0, lb = '0;
    logic [2*N-1:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        la <= lfsr_rst ? lsa : lfsr_nx(la, lm);
        lb <= lfsr_rst ? lsb : lfsr_nx(lb, lm);
        p1 <= 16'(la) * 16'(lb);
        p2 <= p1;
    end
    assign prod = zero_prod ? '0 : p2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int             cyc;
        logic [2*N-1:0] sig;
        logic           pass;
        bit             chk_sig;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   vv_cnt   = 0;
    int   vv_first = -1;

    always @(negedge clk) begin
        if (vec_valid) begin
            vv_cnt++;
            if (vv_first < 0) vv_first = cyc;
        end
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("busy_at_done", busy, 1'b0);
                check("pass", pass, mon_e.pass);
                if (mon_e.chk_sig) check("sig", sig, mon_e.sig);
            end
        end
    end

    task automatic wait_sb(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: %0d results still pending", sb.size());
            sb.delete();
        end
    endtask

    typedef struct {
        int             nv;
        logic [N-1:0]   sa, sb, m;
        logic [2*N-1:0] gxor;
        bit             zero;
        bit             exp_pass;
    } vec_t;
    vec_t tbl[6];

    task automatic run_row(input vec_t v);
        logic [2*N-1:0] ms;
        int m0;
        ms = model(v.nv, v.sa, v.sb, v.m, v.zero);
        @(negedge clk);
        num_vec = CW'(v.nv); seed_a = v.sa; seed_b = v.sb; mask = v.m;
        golden = ms ^ v.gxor; zero_prod = v.zero; start = 1'b1;
        m0 = cyc; vv_cnt = 0; vv_first = -1;
        sb.push_back('{m0 + v.nv + L + 3, ms, v.exp_pass, 1'b1});
        @(negedge clk);
        start = 1'b0;
        wait_sb(v.nv + 40);
        check("vec_count", vv_cnt, v.nv);
        if (v.nv > 0) check("first_vec_cycle", vv_first, m0 + 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, d0cyc, vv0;
        logic p0s;
        logic [2*N-1:0] s0s, ga, gb;

        tbl[0] = '{20, 8'h01, 8'h5A, 8'hB8, 16'h0000, 1'b0, 1'b1};
        tbl[1] = '{20, 8'h01, 8'h5A, 8'hB8, 16'h0001, 1'b0, 1'b0};
        tbl[2] = '{5,  8'h37, 8'h91, 8'hB8, 16'h0000, 1'b1, 1'b1};
        tbl[3] = '{1,  8'hFF, 8'h03, 8'h8E, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{0,  8'h12, 8'h34, 8'hB8, 16'h0000, 1'b0, 1'b1};
        tbl[5] = '{7,  8'h3C, 8'hC3, 8'hB8, 16'h8000, 1'b0, 1'b0};

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lfsr_rst", lfsr_rst, 1'b1);
        check("rst_vec_valid", vec_valid, 1'b0);
        check("rst_sig", sig, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_seed_a", lsa, '0);
        check("rst_lfsr_rst0", lfsr_rst0, 1'b1);
        check("rst_busy0", busy0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Null run: LAT=0 instance checked by hand, LAT=2 instance via scoreboard
        num_vec = '0; seed_a = '0; seed_b = '0; mask = '0; golden = '0; start = 1'b1;
        m0 = cyc; d0cyc = -1; vv0 = 0; p0s = 1'b0; s0s = '1;
        sb.push_back('{m0 + L + 3, '0, 1'b1, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                check("null_load_lfsr_rst0", lfsr_rst0, 1'b1);
                check("null_load_busy0", busy0, 1'b1);
            end
            if (vec_valid0) vv0++;
            if (done0 && d0cyc < 0) begin
                d0cyc = cyc; p0s = pass0; s0s = sig0;
            end
        end
        check("null_done_cycle0", d0cyc, m0 + 3);
        check("null_pass0", p0s, 1'b1);
        check("null_sig0", s0s, '0);
        check("null_vec_valid0", vv0, 0);
        wait_sb(20);

        // Table of full runs
        for (int i = 0; i < 6; i++) run_row(tbl[i]);

        // Abort in the 3rd RUN cycle, then a normal run four cycles later
        @(negedge clk);
        num_vec = CW'(10); seed_a = 8'h01; seed_b = 8'h5A; mask = 8'hB8; golden = '0;
        zero_prod = 1'b0; start = 1'b1; m0 = cyc;
        sb.push_back('{m0 + 5, '0, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_run", vec_valid, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_lfsr_rst", lfsr_rst, 1'b1);
        wait_sb(10);
        repeat (3) @(negedge clk);
        run_row(tbl[0]);

        // Start held high with config changed mid-run
        ga = model(6, 8'h11, 8'h22, 8'hB8, 1'b0);
        gb = model(3, 8'h81, 8'h7E, 8'h8E, 1'b0);
        @(negedge clk);
        num_vec = CW'(6); seed_a = 8'h11; seed_b = 8'h22; mask = 8'hB8; golden = ga; start = 1'b1;
        m0 = cyc;
        sb.push_back('{m0 + 6 + L + 3, ga, 1'b1, 1'b1});
        sb.push_back('{m0 + 6 + L + 3 + 3 + L + 3, gb, 1'b1, 1'b1});
        @(negedge clk);
        num_vec = CW'(3); seed_a = 8'h81; seed_b = 8'h7E; mask = 8'h8E; golden = gb;
        repeat (2) @(negedge clk);
        check("restart_seed_a_held", lsa, 8'h11);
        check("restart_mask_held", lm, 8'hB8);
        begin
            int k = 0;
            while (sb.size() > 1 && k < 60) begin
                @(negedge clk); #1;
                k++;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        wait_sb(40);
        check("restart_seed_a_new", lsa, 8'h81);

        // Async reset in the first DRAIN cycle
        @(negedge clk);
        num_vec = CW'(20); seed_a = 8'h01; seed_b = 8'h5A; mask = 8'hB8; golden = '0; start = 1'b1;
        m0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        check("drain_busy", busy, 1'b1);
        check("drain_lfsr_rst", lfsr_rst, 1'b1);
        check("drain_sig_partial", sig, model(18, 8'h01, 8'h5A, 8'hB8, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        check("arst_lfsr_rst", lfsr_rst, 1'b1);
        check("arst_vec_valid", vec_valid, 1'b0);
        check("arst_sig", sig, '0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_seed_a", lsa, '0);
        check("arst_mask", lm, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_lfsr_rst", lfsr_rst, 1'b1);
        check("post_rst_done", done, 1'b0);
        repeat (30) @(negedge clk);
        check("post_rst_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_bist_ctrl.md
# mul_bist_ctrl

Built-in self-test controller for the 32-bit Dadda multiplier. It holds the two operand LFSRs in load and configures their shared seed/mask values. It sequences a run of pseudo-random operand vectors into the multiplier and compacts the products into a rotate-XOR signature. At the end of the run it compares the signature against a golden value and reports pass/fail. It sits between the test access logic (start/config/result) and the multiplier datapath with its two operand LFSRs.

## Interface
- N, 32, operand width; product width 2N
- CNT_W, 16, vector counter width
- LAT, 2, multiplier pipeline latency in cycles (0..7); prod corresponds to vec_valid LAT cycles earlier
- clk  in  1  single clock, all flops rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- start  in  1  run request, sampled only in IDLE
- abort  in  1  terminate the run, sampled in every state except IDLE
- num_vec  in  CNT_W  number of vectors to apply, captured at start
- seed_a, seed_b  in  N  operand LFSR seeds, captured at start
- mask  in  N  feedback tap mask for both LFSRs, captured at start
- golden  in  2N  expected signature, captured at start
- prod  in  2N  multiplier product
- lfsr_rst  out  1  drives both LFSR rst pins (synchronous load, active-high)
- lfsr_seed_a, lfsr_seed_b, lfsr_mask  out  N  registered captured configuration
- vec_valid  out  1  LFSR outputs are a live operand vector this cycle
- sig  out  2N  current signature
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- pass  out  1  result of the last run, held until the next start

## Operation
- States: IDLE, LOAD, RUN, DRAIN, CHECK. All outputs are registered or a direct decode of the state register.
- IDLE:
  - lfsr_rst=1.
  - On start=1: capture num_vec, seeds, mask and golden; clear pass; go to LOAD.
- LOAD, one cycle:
  - lfsr_rst=1, so the LFSRs load the captured seeds.
  - sig, the vector counter and the valid delay line are cleared.
  - Next state is RUN, or DRAIN if num_vec==0.
- RUN:
  - lfsr_rst=0 and vec_valid=1 for exactly num_vec cycles.
  - Vector 0 is the seed; the LFSRs advance every RUN cycle.
  - The counter counts 0..num_vec-1; go to DRAIN after the last vector.
- DRAIN:
  - lfsr_rst=1, which freezes the LFSRs at the seed.
  - Stay LAT cycles, or 0 cycles when LAT==0 and go straight to CHECK.
- CHECK, one cycle:
  - Register pass <= (sig == golden_captured) and done <= 1.
  - Next state is IDLE.
- Valid delay line:
  - LAT-stage shift of vec_valid; for LAT==0 it is vec_valid itself.
  - When the delayed valid is 1: sig <= {sig[2N-2:0], sig[2N-1]} ^ prod.
  - sig is otherwise held, and is held after done until the next LOAD.
- Abort:
  - abort=1 in LOAD, RUN, DRAIN or CHECK sets the next state to IDLE, done=1 next cycle, pass=0.
  - abort has priority over every other transition.
- start while busy is ignored. abort in IDLE is ignored.
- The counter is CNT_W wide. num_vec = 2^CNT_W-1 is a legal maximum; there is no wrap within a run.

## Timing
- Reset values: state=IDLE, lfsr_rst=1, all captured config 0, vec_valid=0, sig=0, busy=0, done=0, pass=0, delay line 0.
- Cycle numbering: the edge sampling start is edge 0.
  - LOAD: cycle 1.
  - RUN: cycles 2..num_vec+1.
  - DRAIN: LAT cycles.
  - CHECK: cycle num_vec+LAT+2.
  - done=1 and pass valid: cycle num_vec+LAT+3.
- busy is 1 from cycle 1 through the CHECK cycle; it is 0 in the cycle where done=1.
- The last prod is sampled in the final DRAIN cycle (LAT>0), or in the final RUN cycle (LAT==0).
- Abort sampled at edge k: IDLE and done=1 at cycle k+1; the delay line is cleared at the next LOAD.
- rst_n falling mid-run immediately forces all reset values, including lfsr_rst=1, independent of clk.

## Test plan
- **Null run.** N=8, LAT=0, num_vec=0, golden=0, start pulse -> LOAD then CHECK; vec_valid never 1; done at cycle 3; pass=1; sig=0.
- **Zero products.** LAT=2, num_vec=5, prod tied 0, golden=0 -> vec_valid high for cycles 2..6; done at cycle 10; pass=1.
- **Signature vs model.** N=8, seed_a=8'h01, seed_b=8'h5A, mask=8'hB8, num_vec=20, LAT=2, prod driven by an ideal multiplier of the LFSR outputs delayed 2 -> sig equals the bench reference model; golden=model gives pass=1; golden=model^1 gives pass=0.
- **Abort.** Abort asserted in the 3rd RUN cycle -> IDLE next cycle, done=1, pass=0, busy=0. A start 4 cycles later runs normally.
- **Restart protection.** start held high through a whole run, config inputs changed mid-run -> the run is unaffected; a second run begins only from IDLE and uses the newly sampled config.
- **Async reset.** rst_n asserted mid-DRAIN between clock edges -> all outputs take reset values immediately; after release, IDLE with lfsr_rst=1 and done=0.
